maze_map_store: RTL and testbench

//  Sits between the radio packet receiver (16-bit word + valid) and the VGA pixel mux.

---
 rtl/maze_map_store_pkg.sv | 43 ++++
 rtl/maze_map_store_cell_table.sv | 85 ++++++++
 rtl/maze_map_store.sv | 217 +++++++++++++++++++++
 tb/tb_maze_map_store.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_map_store_pkg.sv
// Shared maze definitions used by the map store, the radio receiver and the VGA mux.
// Contents: cell state codes, packet field positions, wall bit order, default grid size.
package maze_defs;

   // Cell state codes carried in packets and stored in the table
   typedef enum logic [2:0] {
      ST_UNVISITED = 3'd0,
      ST_VISITED   = 3'd1,
      ST_WALL      = 3'd2,
      ST_TR7       = 3'd3,
      ST_TR12      = 3'd4,
      ST_TR17      = 3'd5,
      ST_CURRENT   = 3'd6,
      ST_ILLEGAL   = 3'd7
   } cell_state_e;

   // Map store control states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DEMOTE = 2'd1,
      S_CLEAR  = 2'd2
   } fsm_state_e;

   // Packet layout: [15:14]=x, [13:11]=y, [10:8]=state, [7:4]=walls, [3:0] reserved
   localparam int PKT_X_LSB    = 14;
   localparam int PKT_Y_LSB    = 11;
   localparam int PKT_ST_LSB   = 8;
   localparam int PKT_WALL_LSB = 4;

   // Wall bit order within the 4-bit walls field: {N,S,E,W}
   localparam int WALL_N = 3;
   localparam int WALL_S = 2;
   localparam int WALL_E = 1;
   localparam int WALL_W = 0;

   // Default grid geometry
   localparam int GRID_W_DEF = 4;
   localparam int GRID_H_DEF = 5;
   localparam int X_BITS_DEF = 2;
   localparam int Y_BITS_DEF = 3;
   localparam int ERR_W_DEF  = 8;

endpackage

// File: rtl/maze_map_store_cell_table.sv
// maze_cell_table: GRID_W x GRID_H register array of {state[2:0], walls[3:0]}.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset (clears every cell)
//   i_we, i_wr_idx          single write port, linear index y*GRID_W+x
//   i_wr_state, i_wr_walls  write data
//   i_wr_keep_walls         write only the state field, leave walls untouched
//   o_wr_old_state          combinational state of the cell at i_wr_idx (pre-write)
//   i_rd_x, i_rd_y          renderer read address
//   o_rd_state/walls/oor    registered read data, 1-cycle latency
module maze_cell_table
   import maze_defs::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF,
   parameter int X_BITS = X_BITS_DEF,
   parameter int Y_BITS = Y_BITS_DEF,
   parameter int CELLS  = GRID_W * GRID_H,
   parameter int IDX_W  = $clog2(CELLS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [2:0]        i_wr_state,
   input  logic [3:0]        i_wr_walls,
   input  logic              i_wr_keep_walls,
   output logic [2:0]        o_wr_old_state,
   input  logic [X_BITS-1:0] i_rd_x,
   input  logic [Y_BITS-1:0] i_rd_y,
   output logic [2:0]        o_rd_state,
   output logic [3:0]        o_rd_walls,
   output logic              o_rd_oor
);

   logic [2:0] r_state [CELLS];
   logic [3:0] r_walls [CELLS];
   logic [2:0] r_rd_state;
   logic [3:0] r_rd_walls;
   logic       r_rd_oor;

   logic       w_rd_oor;
   logic [IDX_W-1:0] w_rd_idx;

   assign w_rd_oor = (32'(i_rd_x) >= GRID_W) || (32'(i_rd_y) >= GRID_H);
   assign w_rd_idx = IDX_W'(32'(i_rd_y) * GRID_W + 32'(i_rd_x));

   assign o_wr_old_state = r_state[i_wr_idx];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < CELLS; i++) begin
            r_state[i] <= '0;
            r_walls[i] <= '0;
         end
      end else if (i_we) begin
         r_state[i_wr_idx] <= i_wr_state;
         if (!i_wr_keep_walls) begin
            r_walls[i_wr_idx] <= i_wr_walls;
         end
      end
   end

   // Read samples the array before this edge's write lands (pre-write data)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_state <= '0;
         r_rd_walls <= '0;
         r_rd_oor   <= 1'b0;
      end else begin
         r_rd_oor <= w_rd_oor;
         if (w_rd_oor) begin
            r_rd_state <= '0;
            r_rd_walls <= '0;
         end else begin
            r_rd_state <= r_state[w_rd_idx];
            r_rd_walls <= r_walls[w_rd_idx];
         end
      end
   end

   assign o_rd_state = r_rd_state;
   assign o_rd_walls = r_rd_walls;
   assign o_rd_oor   = r_rd_oor;

endmodule

// File: rtl/maze_map_store.sv
// maze_map_store: validates radio maze packets, writes them into the cell table,
// tracks the single current cell, counts explored cells and dropped packets,
// and serves a registered read port to the renderer.
// Ports:
//   CLOCK, RESET_N            clock, asynchronous active-low reset
//   PKT_DATA, PKT_VALID       packet word and valid; PKT_READY high only in IDLE
//   CLEAR                     one-cycle wipe request (wins over a packet)
//   RD_X, RD_Y                read address; RD_STATE/RD_WALLS/RD_OOR one cycle later
//   CUR_X, CUR_Y, CUR_VALID   current robot cell
//   VISIT_CNT, MAP_DONE       explored-cell count and full-map flag
//   ERR_CNT                   saturating dropped-packet count
//   BUSY                      control not in IDLE
module maze_map_store
   import maze_defs::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF,
   parameter int X_BITS = X_BITS_DEF,
   parameter int Y_BITS = Y_BITS_DEF,
   parameter int ERR_W  = ERR_W_DEF
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic [15:0]       PKT_DATA,
   input  logic              PKT_VALID,
   output logic              PKT_READY,
   input  logic              CLEAR,
   input  logic [X_BITS-1:0] RD_X,
   input  logic [Y_BITS-1:0] RD_Y,
   output logic [2:0]        RD_STATE,
   output logic [3:0]        RD_WALLS,
   output logic              RD_OOR,
   output logic [X_BITS-1:0] CUR_X,
   output logic [Y_BITS-1:0] CUR_Y,
   output logic              CUR_VALID,
   output logic [4:0]        VISIT_CNT,
   output logic              MAP_DONE,
   output logic [ERR_W-1:0]  ERR_CNT,
   output logic              BUSY
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int IDX_W = $clog2(CELLS);

   fsm_state_e        r_state;
   fsm_state_e        w_next;

   logic [X_BITS-1:0] r_cur_x;
   logic [Y_BITS-1:0] r_cur_y;
   logic              r_cur_valid;
   logic [IDX_W-1:0]  r_demote_idx;
   logic [IDX_W-1:0]  r_clr_idx;
   logic [4:0]        r_visit;
   logic [ERR_W-1:0]  r_err;

   logic [X_BITS-1:0] w_pkt_x;
   logic [Y_BITS-1:0] w_pkt_y;
   logic [2:0]        w_pkt_st;
   logic [3:0]        w_pkt_walls;
   logic [IDX_W-1:0]  w_pkt_idx;
   logic [IDX_W-1:0]  w_cur_idx;
   logic              w_legal;
   logic              w_ready;
   logic              w_accept;
   logic              w_good;
   logic              w_bad;
   logic              w_same;
   logic              w_is_cur;

   logic              w_we;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [2:0]        w_wr_state;
   logic [3:0]        w_wr_walls;
   logic              w_keep_walls;
   logic [2:0]        w_old_state;
   logic              w_unused;

   assign w_pkt_x     = PKT_DATA[PKT_X_LSB +: X_BITS];
   assign w_pkt_y     = PKT_DATA[PKT_Y_LSB +: Y_BITS];
   assign w_pkt_st    = PKT_DATA[PKT_ST_LSB +: 3];
   assign w_pkt_walls = PKT_DATA[PKT_WALL_LSB +: 4];
   assign w_unused    = ^PKT_DATA[3:0];

   assign w_pkt_idx = IDX_W'(32'(w_pkt_y) * GRID_W + 32'(w_pkt_x));
   assign w_cur_idx = IDX_W'(32'(r_cur_y) * GRID_W + 32'(r_cur_x));

   assign w_legal  = (32'(w_pkt_x) < GRID_W) && (32'(w_pkt_y) < GRID_H) &&
                     (w_pkt_st != ST_ILLEGAL);
   assign w_ready  = (r_state == S_IDLE);
   assign w_accept = PKT_VALID & w_ready & ~CLEAR;
   assign w_good   = w_accept & w_legal;
   assign w_bad    = w_accept & ~w_legal;
   assign w_same   = (w_pkt_x == r_cur_x) && (w_pkt_y == r_cur_y);
   assign w_is_cur = (w_pkt_st == ST_CURRENT);

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_we         = 1'b0;
      w_wr_idx     = '0;
      w_wr_state   = '0;
      w_wr_walls   = '0;
      w_keep_walls = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_good) begin
               w_we       = 1'b1;
               w_wr_idx   = w_pkt_idx;
               w_wr_state = w_pkt_st;
               w_wr_walls = w_pkt_walls;
               if (w_is_cur && r_cur_valid && !w_same) w_next = S_DEMOTE;
            end
         end
         S_DEMOTE: begin
            w_we         = 1'b1;
            w_wr_idx     = r_demote_idx;
            w_wr_state   = ST_VISITED;
            w_keep_walls = 1'b1;
            w_next       = S_IDLE;
         end
         S_CLEAR: begin
            w_we     = 1'b1;
            w_wr_idx = r_clr_idx;
            if (r_clr_idx == IDX_W'(CELLS - 1)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // A wipe request overrides everything, including a walk already in progress
      if (CLEAR) begin
         w_we   = 1'b0;
         w_next = S_CLEAR;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cur_x      <= '0;
         r_cur_y      <= '0;
         r_cur_valid  <= 1'b0;
         r_demote_idx <= '0;
         r_clr_idx    <= '0;
         r_visit      <= '0;
         r_err        <= '0;
      end else begin
         if (w_bad && (r_err != '1)) r_err <= r_err + 1'b1;

         if (CLEAR) begin
            r_clr_idx   <= '0;
            r_cur_valid <= 1'b0;
            r_visit     <= '0;
         end else begin
            if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;

            // Only packet writes move the count; demote and wipe writes never do
            if (w_we && (r_state == S_IDLE)) begin
               if ((w_old_state == ST_UNVISITED) && (w_wr_state != ST_UNVISITED) &&
                   (r_visit < 5'(CELLS)))
                  r_visit <= r_visit + 1'b1;
               else if ((w_old_state != ST_UNVISITED) && (w_wr_state == ST_UNVISITED) &&
                        (r_visit != '0))
                  r_visit <= r_visit - 1'b1;
            end

            if (w_good) begin
               if (w_is_cur) begin
                  if (!r_cur_valid) begin
                     r_cur_x     <= w_pkt_x;
                     r_cur_y     <= w_pkt_y;
                     r_cur_valid <= 1'b1;
                  end else if (!w_same) begin
                     r_demote_idx <= w_cur_idx;
                     r_cur_x      <= w_pkt_x;
                     r_cur_y      <= w_pkt_y;
                  end
               end else if (r_cur_valid && w_same) begin
                  r_cur_valid <= 1'b0;
               end
            end
         end
      end
   end

   maze_cell_table #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_table (
      .i_clk           (CLOCK),
      .i_rst_n         (RESET_N),
      .i_we            (w_we),
      .i_wr_idx        (w_wr_idx),
      .i_wr_state      (w_wr_state),
      .i_wr_walls      (w_wr_walls),
      .i_wr_keep_walls (w_keep_walls),
      .o_wr_old_state  (w_old_state),
      .i_rd_x          (RD_X),
      .i_rd_y          (RD_Y),
      .o_rd_state      (RD_STATE),
      .o_rd_walls      (RD_WALLS),
      .o_rd_oor        (RD_OOR)
   );

   assign PKT_READY = w_ready;
   assign BUSY      = (r_state != S_IDLE);
   assign CUR_X     = r_cur_x;
   assign CUR_Y     = r_cur_y;
   assign CUR_VALID = r_cur_valid;
   assign VISIT_CNT = r_visit;
   assign MAP_DONE  = (r_visit == 5'(CELLS));
   assign ERR_CNT   = r_err;

endmodule

// File: tb/tb_maze_map_store.sv
// Self-checking bench for maze_map_store: directed anchors followed by random
// traffic, compared every cycle against a cell-array reference model.
module tb_maze_map_store;

   logic        CLOCK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [15:0] PKT_DATA = '0;
   logic        PKT_VALID = 1'b0;
   logic        PKT_READY;
   logic        CLEAR = 1'b0;
   logic [1:0]  RD_X = '0;
   logic [2:0]  RD_Y = '0;
   logic [2:0]  RD_STATE;
   logic [3:0]  RD_WALLS;
   logic        RD_OOR;
   logic [1:0]  CUR_X;
   logic [2:0]  CUR_Y;
   logic        CUR_VALID;
   logic [4:0]  VISIT_CNT;
   logic        MAP_DONE;
   logic [7:0]  ERR_CNT;
   logic        BUSY;

   maze_map_store #(
      .GRID_W (4),
      .GRID_H (5),
      .X_BITS (2),
      .Y_BITS (3),
      .ERR_W  (8)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET_N   (RESET_N),
      .PKT_DATA  (PKT_DATA),
      .PKT_VALID (PKT_VALID),
      .PKT_READY (PKT_READY),
      .CLEAR     (CLEAR),
      .RD_X      (RD_X),
      .RD_Y      (RD_Y),
      .RD_STATE  (RD_STATE),
      .RD_WALLS  (RD_WALLS),
      .RD_OOR    (RD_OOR),
      .CUR_X     (CUR_X),
      .CUR_Y     (CUR_Y),
      .CUR_VALID (CUR_VALID),
      .VISIT_CNT (VISIT_CNT),
      .MAP_DONE  (MAP_DONE),
      .ERR_CNT   (ERR_CNT),
      .BUSY      (BUSY)
   );

   always #20 CLOCK = ~CLOCK;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: plain cell arrays plus a few pending-activity counters
   int mst [20];
   int mwl [20];
   int m_cx = 0, m_cy = 0;
   bit m_cv = 1'b0;
   bit m_dem = 1'b0;
   int m_dem_idx = 0;
   int m_clr_left = 0;
   int m_err = 0;
   int e_rs = 0, e_rw = 0;
   bit e_oor = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int cnt = 0;
      bit busy;
      for (int i = 0; i < 20; i++) if (mst[i] != 0) cnt++;
      if (m_clr_left > 0) cnt = 0;
      busy = (m_clr_left > 0) || m_dem;
      chk("rd_state",  RD_STATE,  e_rs);
      chk("rd_walls",  RD_WALLS,  e_rw);
      chk("rd_oor",    RD_OOR,    e_oor);
      chk("pkt_ready", PKT_READY, !busy);
      chk("busy",      BUSY,      busy);
      chk("cur_valid", CUR_VALID, m_cv);
      chk("cur_x",     CUR_X,     m_cx);
      chk("cur_y",     CUR_Y,     m_cy);
      chk("visit_cnt", VISIT_CNT, cnt);
      chk("map_done",  MAP_DONE,  cnt == 20);
      chk("err_cnt",   ERR_CNT,   m_err);
   endtask

   // Drive one cycle of stimulus at a falling edge, advance the model, check at the next falling edge
   task automatic step(input bit v, input logic [15:0] d, input bit clr, input int rx, input int ry);
      int px, py, ps, pw, idx;
      bit ready;
      PKT_VALID = v;
      PKT_DATA  = d;
      CLEAR     = clr;
      RD_X      = rx[1:0];
      RD_Y      = ry[2:0];
      if (rx >= 4 || ry >= 5) begin
         e_oor = 1'b1; e_rs = 0; e_rw = 0;
      end else begin
         e_oor = 1'b0; e_rs = mst[ry*4+rx]; e_rw = mwl[ry*4+rx];
      end
      ready = (m_clr_left == 0) && !m_dem;
      px = int'(d[15:14]); py = int'(d[13:11]); ps = int'(d[10:8]); pw = int'(d[7:4]);
      if (clr) begin
         m_clr_left = 20; m_cv = 1'b0; m_dem = 1'b0;
      end else if (m_clr_left > 0) begin
         mst[20-m_clr_left] = 0; mwl[20-m_clr_left] = 0; m_clr_left--;
      end else if (m_dem) begin
         mst[m_dem_idx] = 1; m_dem = 1'b0;
      end else if (v && ready) begin
         if (px >= 4 || py >= 5 || ps == 7) begin
            if (m_err < 255) m_err++;
         end else begin
            idx = py*4 + px;
            mst[idx] = ps; mwl[idx] = pw;
            if (ps == 6) begin
               if (!m_cv) begin
                  m_cx = px; m_cy = py; m_cv = 1'b1;
               end else if (m_cx != px || m_cy != py) begin
                  m_dem_idx = m_cy*4 + m_cx; m_cx = px; m_cy = py; m_dem = 1'b1;
               end
            end else if (m_cv && m_cx == px && m_cy == py) begin
               m_cv = 1'b0;
            end
         end
      end
      @(negedge CLOCK);
      check_all();
   endtask

   function automatic logic [15:0] pkt(input int x, input int y, input int st, input int w);
      logic [1:0] xb = x[1:0];
      logic [2:0] yb = y[2:0];
      logic [2:0] sb = st[2:0];
      logic [3:0] wb = w[3:0];
      return {xb, yb, sb, wb, 4'h0};
   endfunction

   initial begin
      int x, y, st;
      bit v, c;
      for (int i = 0; i < 20; i++) begin mst[i] = 0; mwl[i] = 0; end

      // Reset state, observed while reset is still held
      @(negedge CLOCK); @(negedge CLOCK);
      check_all();
      chk("reset_ready", PKT_READY, 1);
      chk("reset_err",   ERR_CNT,   0);
      RESET_N = 1'b1;
      step(0, 16'h0, 0, 0, 0);
      chk("rd00_state", RD_STATE, 0);
      chk("rd00_walls", RD_WALLS, 0);

      // First current cell
      step(1, 16'h8E50, 0, 2, 1);
      step(0, 16'h0, 0, 2, 1);
      chk("cur1_rd_state", RD_STATE, 6);
      chk("cur1_rd_walls", RD_WALLS, 4'b0101);
      chk("cur1_x", CUR_X, 2);
      chk("cur1_y", CUR_Y, 1);
      chk("cur1_valid", CUR_VALID, 1);
      chk("cur1_visit", VISIT_CNT, 1);

      // Move current: one demote cycle
      step(1, 16'h0E00, 0, 2, 1);
      chk("demote_ready", PKT_READY, 0);
      chk("demote_busy",  BUSY, 1);
      step(0, 16'h0, 0, 2, 1);
      chk("after_demote_ready", PKT_READY, 1);
      step(0, 16'h0, 0, 2, 1);
      chk("demoted_state", RD_STATE, 1);
      chk("demoted_walls", RD_WALLS, 4'b0101);
      chk("cur2_x", CUR_X, 0);
      chk("cur2_y", CUR_Y, 1);
      chk("cur2_visit", VISIT_CNT, 2);

      // Dropped packets and saturation
      step(1, pkt(1, 6, 1, 4'hF), 0, 1, 1);
      step(1, pkt(1, 1, 7, 4'hF), 0, 1, 1);
      step(0, 16'h0, 0, 1, 1);
      chk("drop_err", ERR_CNT, 2);
      chk("drop_cell", RD_STATE, 0);
      chk("drop_visit", VISIT_CNT, 2);
      for (int i = 0; i < 256; i++) step(1, pkt(i % 4, 5 + (i % 3), 1, 0), 0, 3, 4);
      chk("err_sat", ERR_CNT, 255);

      // Clear colliding with a packet
      step(1, pkt(3, 3, 1, 4'hA), 1, 0, 1);
      for (int i = 0; i < 20; i++) begin
         chk("clear_busy", BUSY, 1);
         step(0, 16'h0, 0, i % 4, i / 4);
      end
      chk("clear_idle", BUSY, 0);
      chk("clear_visit", VISIT_CNT, 0);
      chk("clear_cur_valid", CUR_VALID, 0);
      chk("clear_err_kept", ERR_CNT, 255);
      for (int i = 0; i < 21; i++) step(0, 16'h0, 0, i % 4, (i / 4) % 6);

      // Fill the whole map, then unvisit one cell
      for (int i = 0; i < 20; i++) step(1, pkt(i % 4, i / 4, 1, $urandom_range(0, 15)), 0, 0, 0);
      step(0, 16'h0, 0, 3, 4);
      chk("full_visit", VISIT_CNT, 20);
      chk("full_done", MAP_DONE, 1);
      step(1, pkt(3, 4, 0, 0), 0, 3, 4);
      step(0, 16'h0, 0, 3, 4);
      chk("unvisit_cnt", VISIT_CNT, 19);
      chk("unvisit_done", MAP_DONE, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         c = ($urandom_range(0, 99) < 2);
         v = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 3) == 0) begin
            x = $urandom_range(0, 3); y = $urandom_range(0, 7); st = $urandom_range(0, 7);
         end else begin
            x = $urandom_range(0, 3); y = $urandom_range(0, 4);
            st = ($urandom_range(0, 2) == 0) ? 6 : $urandom_range(0, 6);
         end
         step(v, pkt(x, y, st, $urandom_range(0, 15)), c, $urandom_range(0, 3), $urandom_range(0, 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
